// File: rtl/alu_exec_pkg.sv
// Shared ALU control encodings (mirroring define.v) and small decode helpers
// for the execute stage.
package alu_exec_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_exec_unit_shift_iter.sv
// Iterative 1-bit-per-cycle logical shifter: load latches operand, count and
// direction; done flags the cycle whose step produces the final value.
module alu_shift_iter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dir_left,
    input  logic [DATA_W-1:0]  src,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [DATA_W-1:0]  res
);

    logic [DATA_W-1:0]  acc_q, acc_d, step;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;

    always_comb begin
        step  = dir_q ? (acc_q << 1) : (acc_q >> 1);
        acc_d = acc_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (load) begin
            acc_d = src;
            cnt_d = shamt;
            dir_d = dir_left;
        end else if (cnt_q != '0) begin
            // counter parks at zero, so a full-width shift never wraps
            acc_d = step;
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    assign done = (cnt_q == SHAMT_W'(1));
    assign res  = step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            dir_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle arithmetic/logic ops, iterative SLL/SRL with
// PC stall. Define ALU_FAST_SHIFT_EN to use a one-cycle barrel shifter instead.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         alu_ctrl,
    input  logic [DATA_W-1:0]  src_a,
    input  logic [DATA_W-1:0]  src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               valid,
    output logic               busy,
    output logic               stall
);

    logic [DATA_W-1:0] op_res;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              valid_q, valid_d;

    always_comb begin
        op_res = '0;
        case (alu_ctrl)
            ALU_ADD: op_res = src_a + src_b;
            ALU_SUB: op_res = src_a - src_b;
            ALU_AND: op_res = src_a & src_b;
            ALU_OR:  op_res = src_a | src_b;
            ALU_SLT: op_res = DATA_W'($signed(src_a) < $signed(src_b));
            ALU_EQ:  op_res = DATA_W'(src_a == src_b);
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL: op_res = src_b << shamt;
            ALU_SRL: op_res = src_b >> shamt;
`else
            // only reached with shamt==0; nonzero amounts go to the iterator
            ALU_SLL, ALU_SRL: op_res = src_b;
`endif
            default: op_res = '0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign busy = 1'b0;

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        if (start) begin
            result_d = op_res;
            zero_d   = (op_res == '0);
            valid_d  = 1'b1;
        end
    end
`else
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t            state_q, state_d;
    logic              sh_load, sh_done;
    logic [DATA_W-1:0] sh_res;

    alu_shift_iter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .dir_left (alu_ctrl == ALU_SLL),
        .src      (src_b),
        .shamt    (shamt),
        .done     (sh_done),
        .res      (sh_res)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        sh_load  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (is_shift(alu_ctrl) && (shamt != '0)) begin
                    sh_load = 1'b1;
                    state_d = SHIFT;
                end else begin
                    result_d = op_res;
                    zero_d   = (op_res == '0);
                    valid_d  = 1'b1;
                end
            end
            SHIFT: if (sh_done) begin
                result_d = sh_res;
                zero_d   = (sh_res == '0);
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign busy = (state_q == SHIFT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign valid  = valid_q;
    assign stall  = busy;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage that sits directly downstream of the ALU control decoder.
- Consumes its 4-bit alu_ctrl code plus the two register/immediate operands, and produces a registered result and zero flag.
- ADD/SUB/AND/OR/SLT/EQ complete in one cycle. SLL/SRL run on an iterative 1-bit-per-cycle shifter and hold the PC through a stall output.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width (must satisfy 2^SHAMT_W == DATA_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on a clk edge only when busy==0
- alu_ctrl  in  4  operation code; encodings ADD, SUB, AND, OR, SLT, SLL, SRL, EQ from define.v
- src_a  in  DATA_W  operand A (rs)
- src_b  in  DATA_W  operand B (rt or sign-extended immediate); this is the shifted operand for SLL/SRL
- shamt  in  SHAMT_W  shift amount, used only by SLL/SRL
- result  out  DATA_W  registered result; holds until the next valid
- zero  out  1  registered, equal to (result==0)
- valid  out  1  one-cycle pulse; result/zero updated in the same cycle
- busy  out  1  high while a shift is in progress
- stall  out  1  equal to busy; freezes PC/IF in the single-cycle datapath

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0, zero=1, valid=0, busy=0, shift counter=0, shift accumulator=0. Reset asserted mid-shift aborts the operation; no valid is produced.
- States: IDLE, SHIFT.
- IDLE, start=1, non-shift op: on the next edge result<=f(src_a,src_b), valid<=1, state stays IDLE. Latency is 1 edge.
  - ADD/SUB: modulo 2^DATA_W, no overflow flag.
  - AND/OR: bitwise.
  - SLT: signed compare; result is 1 or 0, zero-extended.
  - EQ: result=(src_a==src_b), i.e. 1 or 0.
  - Any undefined code: result=0, valid=1.
- IDLE, start=1, SLL/SRL with shamt==0: on the next edge result<=src_b, valid<=1, state stays IDLE.
- IDLE, start=1, SLL/SRL with shamt!=0: on the next edge acc<=src_b, cnt<=shamt, dir latched, state<=SHIFT.
- SHIFT, each edge: acc shifts 1 bit (SLL left / SRL logical right, zero fill), cnt<=cnt-1.
  - When cnt==1 on that edge: result<=shifted acc, valid<=1, state<=IDLE.
  - Total latency from the start edge is shamt+1 edges.
- busy = (state==SHIFT); stall = busy.
- start while busy: ignored, with no queueing. Operand inputs are ignored while busy (latched at the start edge).
- start in the same cycle valid pulses (state back in IDLE): accepted normally, so back-to-back ops are allowed.
- valid is never high for more than one cycle per accepted start.
- Max shamt (31): 32 edges total; the counter must not wrap.
- zero is updated only together with valid.

Optional Feature:
- ALU_FAST_SHIFT_EN defined: SLL/SRL use a combinational barrel shifter. Every op, shamt included, completes in exactly 1 edge; SHIFT state, acc and cnt are not built; busy and stall are tied to 0.
- ALU_FAST_SHIFT_EN undefined: iterative shifter as described above.

Decomposition:
- alu_ctrl operation encodings come from the shared define.v.
- State encodings (IDLE, SHIFT) are local constants in this module, not shared.
- One natural sub-module: alu_shift_iter (acc/cnt registers, one-bit step, done pulse). alu_exec_unit owns the FSM, the 1-cycle ops and the result register.
- Under ALU_FAST_SHIFT_EN, alu_shift_iter is not instantiated.

Test Plan:
- Reset mid-shift: start SLL shamt=10 src_b=0x1, assert rst at edge 4 → valid never pulses; result=0, zero=1, busy=0 immediately and after release.
- ADD/SUB/SLT/EQ: ADD 0x7FFFFFFF+1 → 0x80000000 at edge 1; SUB 5-5 → 0, zero=1; SLT 0xFFFFFFFF<1 → 1; EQ 3,3 → 1, zero=0; each valid a single pulse.
- SLL/SRL timing: SLL src_b=0x1 shamt=4 → busy/stall high 4 cycles, valid at edge 5, result=0x10; SRL src_b=0x80000000 shamt=31 → result=0x1 at edge 32; SLL shamt=0 src_b=0xABCD → 0xABCD at edge 1, busy never set.
- Start during busy: start SRL shamt=3, then start ADD 1+1 on edges 1–2 → ADD ignored; single valid at edge 4 with the shift result.
- Back-to-back: AND 0xF0F0&0xFF00 then OR same operands on consecutive cycles → valid on 2 consecutive cycles, 0xF000 then 0xFFF0.
- ALU_FAST_SHIFT_EN build: SLL 0x1 shamt=31 → 0x80000000 at edge 1; busy and stall stay 0 throughout.
